// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: size encodings, MMIO
// register offsets and error-status bit positions.
package dmem_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b100;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b001;

    // MMIO offsets expressed as word index, i.e. addr[3:2]
    localparam logic [1:0] OFF_CYCLE   = 2'd0;
    localparam logic [1:0] OFF_GPIO    = 2'd1;
    localparam logic [1:0] OFF_ERRST   = 2'd2;
    localparam logic [1:0] OFF_ERRADDR = 2'd3;

    localparam int ERR_ALIGN_BIT = 0;
    localparam int ERR_RANGE_BIT = 1;

    function automatic logic is_onehot3(input logic [2:0] s);
        return (s == SZ_BYTE) || (s == SZ_HALF) || (s == SZ_WORD);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by the RAM and GPIO paths: builds the merged
// store word and byte enables, and extracts right-justified load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] wr_word,
    output logic [3:0]  be,
    output logic [31:0] rd_data
);

    logic [31:0] wdata_rep;

    always_comb begin
        be        = 4'b0000;
        rd_data   = 32'h0;
        wdata_rep = wdata;
        case (size)
            SZ_WORD: begin
                be        = 4'b1111;
                rd_data   = old_word;
                wdata_rep = wdata;
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                rd_data   = {16'h0, old_word[16*addr_lo[1] +: 16]};
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                rd_data   = {24'h0, old_word[8*addr_lo +: 8]};
                wdata_rep = {4{wdata[7:0]}};
            end
            default: begin
                be        = 4'b0000;
                rd_data   = 32'h0;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        wr_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data responder: word-organised RAM plus a 16-byte MMIO window
// (cycle counter, GPIO, sticky error status and first-error address).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h10010000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] RAM_SPAN = 32'(4 * DEPTH);

    logic [31:0] mem_q [DEPTH];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] gpio_q, gpio_d;
    logic [1:0]  errst_q, errst_d;
    logic [31:0] erraddr_q, erraddr_d;
    logic        err_q, err_d;

    logic [31:0] ram_off;
    logic [AW-1:0] ram_idx;
    logic        ram_hit, mmio_hit;
    logic        bad_align, bad_range, valid;
    logic        rd_en, wr_en, bad_access;
    logic [31:0] mmio_word, old_word;
    logic [31:0] wr_word, rd_data;
    logic [3:0]  be;

    // Subtracting the base lets one unsigned compare reject addresses on both sides
    always_comb begin
        ram_off    = addr - RAM_BASE;
        ram_hit    = ram_off < RAM_SPAN;
        ram_idx    = ram_off[AW+1:2];
        mmio_hit   = addr[31:4] == MMIO_BASE[31:4];
        bad_align  = !is_onehot3(size)
                   || ((size == SZ_HALF) && addr[0])
                   || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        bad_range  = !ram_hit && !mmio_hit;
        valid      = !bad_align && !bad_range;
        rd_en      = cs && re && !we && valid;
        wr_en      = cs && we && valid;
        bad_access = cs && !valid;
    end

    always_comb begin
        case (addr[3:2])
            OFF_CYCLE:   mmio_word = cycle_q;
            OFF_GPIO:    mmio_word = gpio_q;
            OFF_ERRST:   mmio_word = {30'h0, errst_q};
            OFF_ERRADDR: mmio_word = erraddr_q;
            default:     mmio_word = 32'h0;
        endcase
        old_word = ram_hit ? mem_q[ram_idx] : mmio_word;
    end

    dmem_lane_align u_lane_align (
        .size     (size),
        .addr_lo  (addr[1:0]),
        .old_word (old_word),
        .wdata    (wdata),
        .wr_word  (wr_word),
        .be       (be),
        .rd_data  (rd_data)
    );

    assign rdata    = rd_en ? rd_data : 32'h0;
    assign gpio_out = gpio_q;
    assign err      = err_q;

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        gpio_d    = gpio_q;
        errst_d   = errst_q;
        erraddr_d = erraddr_q;
        if (wr_en && mmio_hit && (addr[3:2] == OFF_GPIO)) begin
            gpio_d = wr_word;
        end
        // Status bits live in lane 0, so only a store touching lane 0 can clear them
        if (wr_en && mmio_hit && (addr[3:2] == OFF_ERRST)) begin
            errst_d = errst_q & ~(be[0] ? wdata[1:0] : 2'b00);
        end
        if (bad_access) begin
            errst_d[ERR_ALIGN_BIT] = errst_q[ERR_ALIGN_BIT] | bad_align;
            errst_d[ERR_RANGE_BIT] = errst_q[ERR_RANGE_BIT] | bad_range;
            if (errst_q == 2'b00) erraddr_d = addr;
        end
        err_d = |errst_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q   <= 32'h0;
            gpio_q    <= 32'h0;
            errst_q   <= 2'b00;
            erraddr_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            gpio_q    <= gpio_d;
            errst_q   <= errst_d;
            erraddr_q <= erraddr_d;
            err_q     <= err_d;
        end
    end

    // RAM is not reset, but a store coinciding with reset is still dropped
    always_ff @(posedge clk) begin
        if (rst && wr_en && ram_hit) begin
            mem_q[ram_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, lane merging, error capture,
// cycle counter and GPIO behaviour around reset.
module tb_dmem_responder;

    localparam logic [2:0] B = 3'b100;
    localparam logic [2:0] H = 3'b010;
    localparam logic [2:0] W = 3'b001;

    localparam logic [31:0] A_CYCLE = 32'hFFFF0000;
    localparam logic [31:0] A_GPIO  = 32'hFFFF0004;
    localparam logic [31:0] A_ERRST = 32'hFFFF0008;
    localparam logic [31:0] A_ERRAD = 32'hFFFF000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0, we = 1'b0, re = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [2:0]  size = 3'b001;
    logic [31:0] rdata, gpio_out;
    logic        err;

    int checks = 0;
    int failures = 0;

    dmem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .wdata    (wdata),
        .size     (size),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        cs = 1'b0; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0; size = W;
    endtask

    // Inputs change just after a falling edge; one call spans exactly one rising edge.
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d; size = s;
        #1;
        chk("wr_cycle_rdata", rdata, 32'h0);
        @(negedge clk);
        idle();
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] exp);
        cs = 1'b1; we = 1'b0; re = 1'b1; addr = a; wdata = 32'h0; size = s;
        #1;
        chk(tag, rdata, exp);
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        ld("rst_cycle", A_CYCLE, W, 32'h0);
        ld("rst_errst", A_ERRST, W, 32'h0);

        // Ten rising edges out of reset
        rst = 1'b1;
        repeat (10) @(negedge clk);
        ld("cycle_10", A_CYCLE, W, 32'd10);

        st(32'h10010004, 32'hDEADBEEF, W);
        ld("lw_04", 32'h10010004, W, 32'hDEADBEEF);
        ld("lh_06", 32'h10010006, H, 32'h0000DEAD);
        ld("lb_05", 32'h10010005, B, 32'h000000BE);
        ld("lb_04", 32'h10010004, B, 32'h000000EF);

        st(32'h10010006, 32'h12345677, B);
        ld("sb_merge", 32'h10010004, W, 32'hDE77BEEF);
        st(32'h10010004, 32'hAAAA5555, H);
        ld("sh_merge", 32'h10010004, W, 32'hDE775555);

        st(32'h10010000, 32'h11111111, W);
        ld("lw_00_seed", 32'h10010000, W, 32'h11111111);

        ld("lw_misalign", 32'h10010002, W, 32'h0);
        chk("err_after_misalign", {31'h0, err}, 32'h1);
        ld("errst_1", A_ERRST, W, 32'h1);
        ld("erraddr_1", A_ERRAD, W, 32'h10010002);
        st(32'h10010000, 32'h00000000, W);
        ld("lw_00_zeroed", 32'h10010000, W, 32'h0);
        st(32'h00000000, 32'h55555555, W);
        ld("errst_3", A_ERRST, W, 32'h3);
        ld("erraddr_kept", A_ERRAD, W, 32'h10010002);
        ld("lb_errst", A_ERRST, B, 32'h3);
        st(A_ERRST, 32'h00000003, W);
        chk("err_cleared", {31'h0, err}, 32'h0);
        ld("errst_cleared", A_ERRST, W, 32'h0);

        st(32'h10010000, 32'hFFFFFFFF, 3'b011);
        ld("badsize_mem", 32'h10010000, W, 32'h0);
        ld("badsize_errst", A_ERRST, W, 32'h1);
        ld("badsize_erraddr", A_ERRAD, W, 32'h10010000);
        // A byte store into lane 1 of ERR_STATUS must not clear anything
        st(A_ERRST + 32'd1, 32'h000000FF, B);
        ld("w1c_lane1", A_ERRST, W, 32'h1);
        st(A_ERRST, 32'h00000001, B);
        ld("w1c_lane0", A_ERRST, W, 32'h0);

        // Counter wrap: preload near the top, then watch it roll over
        force dut.cycle_q = 32'hFFFFFFFE;
        #1;
        release dut.cycle_q;
        ld("cycle_fffe", A_CYCLE, W, 32'hFFFFFFFE);
        ld("cycle_ffff", A_CYCLE, W, 32'hFFFFFFFF);
        ld("cycle_wrap", A_CYCLE, W, 32'h0);
        st(A_CYCLE, 32'h12345678, W);
        ld("cycle_wr_ignored", A_CYCLE, W, 32'd2);
        ld("cycle_wr_noerr", A_ERRST, W, 32'h0);

        st(A_GPIO, 32'hCAFEF00D, W);
        chk("gpio_word", gpio_out, 32'hCAFEF00D);
        st(A_GPIO + 32'd1, 32'h00000055, B);
        chk("gpio_byte", gpio_out, 32'hCAFE550D);
        ld("gpio_rd_half", A_GPIO + 32'd2, H, 32'h0000CAFE);
        st(32'h00000000, 32'h0, W);
        chk("err_before_rst", {31'h0, err}, 32'h1);

        // Reset edge together with a GPIO store: reset wins
        rst = 1'b0;
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = A_GPIO; wdata = 32'h1; size = W;
        @(negedge clk);
        rst = 1'b1;
        idle();
        chk("rst_gpio_wins", gpio_out, 32'h0);
        chk("rst_err_clr", {31'h0, err}, 32'h0);
        ld("rst_cycle_0", A_CYCLE, W, 32'h0);
        ld("ram_persist", 32'h10010004, W, 32'hDE775555);
        ld("oor_read", 32'h10011000, W, 32'h0);
        ld("oor_errst", A_ERRST, W, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%08h exp=%08h", 32'h0, 32'h1);
        $fatal(1, "timeout");
    end

endmodule
